// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD FIFO unloader: FSM state encoding,
// the LCD command prefix byte and the baud divisor calculation.
package lcd_pkg;

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP, GAP} state_t;

  localparam logic [7:0] LCD_CMD = 8'hFE;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: loads a byte on start, sends start, 8 data bits LSB first and
// STOP_BITS stop bits, each CLKS_PER_BIT clocks; done flags the last stop cycle.
module uart_tx_core
  import lcd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign done    = (state == STOP) && bit_end && (bit_idx == STOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
    end
  end

  // tx is updated one clock ahead so each level appears exactly on a bit boundary
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    if (state != IDLE) cnt_nxt = bit_end ? '0 : cnt + CW'(1);
    case (state)
      IDLE: if (start) begin
        shreg_nxt   = data;
        tx_nxt      = 1'b0;
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        state_nxt   = START;
      end
      START: if (bit_end) begin
        tx_nxt    = shreg[0];
        shreg_nxt = shreg >> 1;
        state_nxt = DATA;
      end
      DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
          tx_nxt      = 1'b1;
          bit_idx_nxt = '0;
          state_nxt   = STOP;
        end else begin
          tx_nxt      = shreg[0];
          shreg_nxt   = shreg >> 1;
          bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: if (bit_end) begin
        if (bit_idx == STOP_LAST) begin
          bit_idx_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_fifo_unloader.sv
// Pops bytes from the LCD message FIFO and sends each one as an 8N1 frame to the
// serial LCD, followed by an idle gap so the display can digest commands.
module lcd_fifo_unloader
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1,
  parameter int GAP_CLKS  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] q,
  input  logic       rdempty,
  output logic       rdreq,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int            CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int            GW           = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GW-1:0] GAP_LAST     = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("lcd_fifo_unloader: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("lcd_fifo_unloader: STOP_BITS must be 1 or 2");
  end

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          tx_done;

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == LOAD),
    .data  (q),
    .tx    (tx),
    .done  (tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // START stands for the whole frame here; the core tracks start/data/stop bits
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE:  if (!rdempty) state_nxt = POP;
      POP:   state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (tx_done) state_nxt = (GAP_CLKS > 0) ? GAP : IDLE;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdreq     = (state == POP);
  assign busy      = (state != IDLE);
  assign byte_done = tx_done;

endmodule

// File: tb/tb_lcd_fifo_unloader.sv
// Bench for lcd_fifo_unloader: a FIFO model feeds bytes, a UART line monitor
// decodes the serial output and timing is compared against the frame rules.
module tb_lcd_fifo_unloader;
  import lcd_pkg::*;

  localparam int CPB        = 16;
  localparam int FRAME_CLKS = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] q = '0;
  logic       rdempty;
  logic       rdreq, tx, busy, byte_done;

  always #5 clk = ~clk;

  lcd_fifo_unloader #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .STOP_BITS (1),
    .GAP_CLKS  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q         (q),
    .rdempty   (rdempty),
    .rdreq     (rdreq),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  // FIFO model: written by the stimulus, read (normal mode) on rdreq
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int bad_reads = 0;
  int cyc = 0;

  assign rdempty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdreq) begin
      if (rd_ptr == wr_ptr) bad_reads <= bad_reads + 1;
      else begin
        q      <= mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // event recorder
  int   rdreq_cyc[$];
  int   done_cyc[$];
  int   busy_fall[$];
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rdreq) rdreq_cyc.push_back(cyc);
    if (byte_done) done_cyc.push_back(cyc);
    if (rst_n && prev_busy && !busy) busy_fall.push_back(cyc);
    prev_busy <= busy;
  end

  // UART line monitor: records every complete frame, drops frames cut by reset
  logic [9:0] frames[$];
  bit         frame_ok[$];
  int         frame_start[$];
  logic       mon_prev_tx;
  logic [9:0] mon_fr;
  bit         mon_ok, mon_ab;
  int         mon_st;

  initial begin
    mon_prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mon_prev_tx && tx === 1'b0) begin
        mon_st = cyc;
        mon_fr = '0;
        mon_ok = 1'b1;
        mon_ab = 1'b0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
          if (i != 0) @(negedge clk);
          if (!rst_n) begin
            mon_ab = 1'b1;
            break;
          end
          if (i % CPB == 0) mon_fr[i / CPB] = tx;
          else if (tx !== mon_fr[i / CPB]) mon_ok = 1'b0;
        end
        if (!mon_ab) begin
          frames.push_back(mon_fr);
          frame_ok.push_back(mon_ok);
          frame_start.push_back(mon_st);
        end
      end
      mon_prev_tx = tx;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] uart_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int n, input int limit, input string tag);
    int k = 0;
    while (done_cyc.size() < n && k < limit) begin
      tick();
      k++;
    end
    check_val(tag, 32'(done_cyc.size() >= n), 1);
  endtask

  initial begin
    int         bad;
    int         f0, d0, r0;
    bit         seen;
    logic [7:0] msg_b [27];
    logic [7:0] rnd_b [16];
    int         push_c [16];
    string      s1, s2;

    // reset held with data waiting
    rst_n = 1'b0;
    push(LCD_CMD);
    bad = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1 || rdreq !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0) bad++;
    end
    check_val("reset_outs", bad, 0);
    check_val("reset_no_read", rdreq_cyc.size(), 0);

    // single byte 0xFE
    rst_n = 1'b1;
    wait_done(1, 400, "fe_done_seen");
    repeat (20) tick();
    check_val("fe_rdreq_cnt", rdreq_cyc.size(), 1);
    check_val("fe_done_cnt", done_cyc.size(), 1);
    check_val("fe_frame_cnt", frames.size(), 1);
    check_val("fe_frame_bits", frames[0], uart_frame(8'hFE));
    check_val("fe_bit_hold", frame_ok[0], 1);
    check_val("fe_done_pos", done_cyc[0] - frame_start[0], FRAME_CLKS - 1);
    check_val("fe_rdreq_to_start", frame_start[0] - rdreq_cyc[0], 2);
    check_val("fe_busy_fall", busy_fall[0] - done_cyc[0], 5);

    // back-to-back 0xFE, 0x01
    push(8'hFE);
    push(8'h01);
    wait_done(3, 800, "b2b_done_seen");
    repeat (300) tick();
    check_val("b2b_rdreq_cnt", rdreq_cyc.size(), 3);
    check_val("b2b_frame1", frames[1], uart_frame(8'hFE));
    check_val("b2b_frame2", frames[2], uart_frame(8'h01));
    check_val("b2b_rdreq_gap", rdreq_cyc[2] - done_cyc[1], 6);
    check_val("b2b_bad_reads", bad_reads, 0);

    // empty FIFO
    bad = 0;
    repeat (1000) begin
      tick();
      if (rdreq !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_val("empty_idle", bad, 0);
    check_val("empty_no_read", rdreq_cyc.size(), 3);

    // reset during data bit 3 of 0x55
    push(8'h55);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (tx === 1'b0) seen = 1'b1;
    end
    check_val("rst_start_seen", seen, 1);
    repeat (72) tick();
    check_val("rst_bit3_level", tx, 0);
    rst_n = 1'b0;
    #1;
    check_val("rst_tx_async", tx, 1);
    check_val("rst_busy_async", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    check_val("rst_frame_dropped", frames.size(), 3);
    push(8'hA5);
    wait_done(4, 400, "rst_done_seen");
    repeat (10) tick();
    check_val("rst_frame_cnt", frames.size(), 4);
    check_val("rst_frame_a5", frames[3], uart_frame(8'hA5));

    // full 27-byte LCD message
    s1 = "SparkFun LCD";
    s2 = "FIFO unload";
    msg_b[0] = LCD_CMD;
    msg_b[1] = 8'h01;
    for (int i = 0; i < 12; i++) msg_b[2 + i] = s1[i];
    msg_b[14] = LCD_CMD;
    msg_b[15] = 8'hC0;
    for (int i = 0; i < 11; i++) msg_b[16 + i] = s2[i];
    f0 = frames.size();
    d0 = done_cyc.size();
    for (int i = 0; i < 27; i++) push(msg_b[i]);
    wait_done(d0 + 27, 6000, "msg_done_seen");
    repeat (20) tick();
    check_val("msg_frame_cnt", frames.size() - f0, 27);
    check_val("msg_done_cnt", done_cyc.size() - d0, 27);
    for (int i = 0; i < 27; i++)
      check_val($sformatf("msg_byte_%0d", i), frames[f0 + i], uart_frame(msg_b[i]));

    // random bytes with random arrival times
    f0 = frames.size();
    d0 = done_cyc.size();
    r0 = rdreq_cyc.size();
    for (int i = 0; i < 16; i++) begin
      rnd_b[i]  = 8'($urandom_range(0, 255));
      push_c[i] = cyc;
      push(rnd_b[i]);
      repeat ($urandom_range(0, 250)) tick();
    end
    wait_done(d0 + 16, 16 * 400, "rnd_done_seen");
    repeat (20) tick();
    check_val("rnd_frame_cnt", frames.size() - f0, 16);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("rnd_byte_%0d", i), frames[f0 + i], uart_frame(rnd_b[i]));
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      if (rdreq_cyc[r0 + i] - done_cyc[d0 + i - 1] < 6) bad++;
      if (push_c[i] <= done_cyc[d0 + i - 1] && rdreq_cyc[r0 + i] - done_cyc[d0 + i - 1] != 6) bad++;
    end
    check_val("rnd_spacing", bad, 0);

    // whole-run invariants
    bad = 0;
    for (int i = 0; i < frames.size(); i++) begin
      if (!frame_ok[i]) bad++;
      if (done_cyc[i] - frame_start[i] != FRAME_CLKS - 1) bad++;
    end
    check_val("all_frame_timing", bad, 0);
    check_val("all_done_vs_frames", done_cyc.size(), frames.size());
    check_val("all_bad_reads", bad_reads, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_fifo_unloader.md
Name: lcd_fifo_unloader

Overview:
Read side of the LCD message FIFO. Pops bytes from the FIFO (normal, non-show-ahead read mode) and serializes each one as an 8N1 UART frame on the serial line to the SparkFun 16x2 serial LCD. Sits between the FIFO read port and the board's LCD RX pin. Adds a programmable idle gap after each byte so the display has time to process commands such as 0xFE 0x01 (clear).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), must be >= 2 (elaboration error otherwise)
STOP_BITS, 1, number of stop bits (1 or 2)
GAP_CLKS, 0, idle clocks inserted after each frame's stop bit(s); 0 means no gap state

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
q  in  8  FIFO read data; valid the cycle after rdreq
rdempty  in  1  FIFO empty flag
rdreq  out  1  FIFO read request; one-cycle pulse per byte
tx  out  1  UART serial output; idle high
busy  out  1  high whenever state != IDLE
byte_done  out  1  one-cycle pulse on the last stop-bit cycle of each frame

Behaviour:
- Reset values (async, while rst_n=0): state=IDLE, tx=1, rdreq=0, busy=0, byte_done=0, counters=0, shift register=0.
- States: IDLE, POP, LOAD, START, DATA, STOP, GAP.
- IDLE: if rdempty=0, go to POP; otherwise stay.
- POP: rdreq=1 for exactly this cycle (decoded from the registered state). Next state is LOAD.
- LOAD: capture q into an 8-bit shift register. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index counter 0..7.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. byte_done=1 on its final cycle. Next state is GAP if GAP_CLKS>0, else IDLE.
- GAP: tx=1 for GAP_CLKS cycles, then IDLE.
- tx is a registered output; no glitches.
- Frame length is (1+8+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first start-bit cycle.
- Latency:
  - rdempty seen low in IDLE at cycle N -> rdreq high at N+1 -> q captured at N+2 -> tx low from N+3.
  - Back-to-back bytes: next rdreq is GAP_CLKS+2 cycles after the byte_done cycle.
- Baud counter width is $clog2(CLKS_PER_BIT). The counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- rdempty is sampled only in IDLE. Changes during POP through GAP are ignored. The FIFO is never read while empty.
- q is sampled only in LOAD.
- Reset mid-frame: tx returns high immediately and asynchronously, and the partially sent byte is lost. After rst_n rises, operation resumes from IDLE and the next byte is sent as a complete frame.
- No flow control from the LCD; pacing comes only from the baud rate and GAP_CLKS.

Decomposition:
- Shared package lcd_pkg holds:
  - the state enum (IDLE, POP, LOAD, START, DATA, STOP, GAP);
  - LCD_CMD = 8'hFE;
  - the calc_clks_per_bit function.
- One natural sub-module, uart_tx_core: serializer with baud counter.
  - Inputs: start, data[7:0].
  - Outputs: tx, done.
- lcd_fifo_unloader keeps the FIFO handshake and gap timing.

Test Plan:
- Simulation settings: CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16), STOP_BITS=1, GAP_CLKS=4 unless stated.
- Reset: hold rst_n=0 with rdempty=0 -> tx=1, rdreq=0, busy=0, byte_done=0 throughout.
- Single byte 0xFE:
  - Exactly one rdreq pulse.
  - tx sequence 0,0,1,1,1,1,1,1,1,1, each level held 16 cycles.
  - byte_done pulses once, at cycle 160 of the frame.
  - busy then falls after 4 gap cycles.
- Back-to-back 0xFE, 0x01:
  - Exactly two rdreq pulses.
  - Second rdreq occurs 6 cycles after the first byte_done.
  - Second frame bits are 0,1,0,0,0,0,0,0,0,1.
  - No extra read once rdempty=1.
- Empty FIFO: rdempty=1 for 1000 cycles -> rdreq never asserted, tx=1, busy=0.
- Reset mid-frame: drop rst_n during data bit 3 of 0x55.
  - tx goes to 1 in the same cycle.
  - After release, the next byte 0xA5 is sent as a complete, correct frame.
- Full message: preload the FIFO with the 27-byte LCD message (0xFE, 0x01, text, 0xFE, 0xC0, text). A UART monitor decodes 27 bytes that match in order, with 27 byte_done pulses.
